// File: rtl/uar_tx_arbiter.sv
// uar_tx_arbiter: round-robin arbiter that shares the UART TX FIFO write port among byte-stream requesters.
// A grant is held until the message's last byte, or force-released after MAX_BURST bytes.
module uar_tx_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 16
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic                      Enable,
   input  logic [N_REQ-1:0]          Req_valid,
   input  logic [N_REQ*DATA_W-1:0]   Req_data,
   input  logic [N_REQ-1:0]          Req_last,
   output logic [N_REQ-1:0]          Req_ready,
   input  logic                      Fifo_full,
   output logic                      Fifo_wr,
   output logic [DATA_W-1:0]         Fifo_data,
   output logic [N_REQ-1:0]          Grant,
   output logic                      Busy
);
   localparam int IW = $clog2(N_REQ);
   typedef enum logic {IDLE, XFER} state_t;
   state_t state, state_n;
   logic [IW-1:0] idx, rr_ptr, pick, j;
   logic [7:0] burst_cnt;
   logic pick_vld, xfer, rel;
   // Scan from farthest to nearest so the nearest valid index after rr_ptr wins.
   always_comb begin
      pick_vld = 1'b0;
      pick = '0;
      j = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         j = IW'((int'(rr_ptr) + k) % N_REQ);
         if (Req_valid[j]) begin
            pick_vld = 1'b1;
            pick = j;
         end
      end
   end
   always_comb begin
      state_n = state;
      Req_ready = '0;
      xfer = 1'b0;
      rel = 1'b0;
      if (state == IDLE)
         state_n = (Enable && pick_vld) ? XFER : IDLE;
      else begin
         Req_ready[idx] = Enable & ~Fifo_full;
         xfer = Req_valid[idx] & Req_ready[idx];
         rel = xfer & (Req_last[idx] | (burst_cnt == 8'(MAX_BURST - 1)));
         state_n = rel ? IDLE : XFER;
      end
   end
   assign Fifo_wr = xfer;
   assign Fifo_data = Req_data[idx*DATA_W +: DATA_W];
   always_ff @(posedge Clk or posedge Rst)
      if (Rst) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge Clk or posedge Rst)
      if (Rst) begin
         Grant <= '0;
         idx <= '0;
         rr_ptr <= IW'(N_REQ - 1);
         burst_cnt <= '0;
         Busy <= 1'b0;
      end else begin
         Busy <= (state_n == XFER);
         if (state == IDLE && state_n == XFER) begin
            Grant <= N_REQ'(1) << pick;
            idx <= pick;
            burst_cnt <= '0;
         end else if (xfer)
            burst_cnt <= burst_cnt + 8'd1;
         if (rel) begin
            Grant <= '0;
            rr_ptr <= idx;
         end
      end
endmodule

// File: tb/tb_uar_tx_arbiter.sv
// tb_uar_tx_arbiter: directed checks of arbitration order, burst rotation, stalls and async reset.
module tb_uar_tx_arbiter;
   logic Clk, Rst, Enable, Fifo_full, Fifo_wr, Busy;
   logic [3:0] Req_valid, Req_last, Req_ready, Grant;
   logic [31:0] Req_data;
   logic [7:0] Fifo_data;
   int total = 0, bad = 0;
   int rem[4];
   logic [7:0] nxt[4];
   bit ul[4];
   logic [7:0] log_q[$], exp_q[$];

   uar_tx_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_BURST(16)) dut (
      .Clk(Clk), .Rst(Rst), .Enable(Enable), .Req_valid(Req_valid), .Req_data(Req_data),
      .Req_last(Req_last), .Req_ready(Req_ready), .Fifo_full(Fifo_full), .Fifo_wr(Fifo_wr),
      .Fifo_data(Fifo_data), .Grant(Grant), .Busy(Busy));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         Req_valid[i] = rem[i] > 0;
         Req_data[i*8 +: 8] = nxt[i];
         Req_last[i] = ul[i] && rem[i] == 1;
      end
   endtask

   // Sample handshake and FIFO write before the edge, then advance the requester model.
   task automatic cyc();
      logic [3:0] hs;
      hs = Req_valid & Req_ready;
      if (Fifo_wr) log_q.push_back(Fifo_data);
      @(negedge Clk);
      for (int i = 0; i < 4; i++)
         if (hs[i]) begin
            rem[i]--;
            nxt[i]++;
         end
      drive();
      #1;
   endtask

   task automatic rst_dut();
      Rst = 1'b1;
      Enable = 1'b1;
      Fifo_full = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rem[i] = 0;
         ul[i] = 1'b1;
         nxt[i] = 8'h00;
      end
      drive();
      @(negedge Clk);
      Rst = 1'b0;
      log_q.delete();
      exp_q.delete();
      #1;
   endtask

   task automatic cmp_log(input string tag);
      chk({tag, "_count"}, log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), log_q[i], exp_q[i]);
   endtask

   initial begin
      logic [3:0] gseq [8];
      Rst = 1'b1;
      Enable = 1'b1;
      Fifo_full = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rem[i] = 1;
         ul[i] = 1'b1;
         nxt[i] = 8'h00;
      end
      drive();
      @(negedge Clk);
      @(negedge Clk);
      #1;
      chk("rst_grant", Grant, 4'h0);
      chk("rst_busy", Busy, 1'b0);
      chk("rst_ready", Req_ready, 4'h0);
      chk("rst_wr", Fifo_wr, 1'b0);

      // Single 3-byte message from requester 0
      rst_dut();
      rem[0] = 3;
      nxt[0] = 8'h41;
      drive();
      #1;
      chk("t1_idle_grant", Grant, 4'h0);
      cyc();
      chk("t1_grant", Grant, 4'h1);
      chk("t1_busy", Busy, 1'b1);
      chk("t1_wr0", Fifo_wr, 1'b1);
      chk("t1_d0", Fifo_data, 8'h41);
      chk("t1_ready", Req_ready, 4'h1);
      cyc();
      chk("t1_d1", Fifo_data, 8'h42);
      cyc();
      chk("t1_d2", Fifo_data, 8'h43);
      cyc();
      chk("t1_rel_grant", Grant, 4'h0);
      chk("t1_rel_busy", Busy, 1'b0);
      exp_q = '{8'h41, 8'h42, 8'h43};
      cmp_log("t1_log");
      // rr_ptr=0 now, so requester 1 beats requester 0
      rem[0] = 1;
      rem[1] = 1;
      drive();
      #1;
      cyc();
      chk("t1_rr_next", Grant, 4'h2);

      // All four requesters, 1-byte messages each
      rst_dut();
      for (int i = 0; i < 4; i++) begin
         rem[i] = 1;
         nxt[i] = 8'hB0 + 8'(i);
      end
      drive();
      #1;
      gseq = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8};
      for (int c = 0; c < 8; c++) begin
         chk($sformatf("t2_grant_c%0d", c), Grant, gseq[c]);
         cyc();
      end
      exp_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
      cmp_log("t2_log");

      // Requester 2 streams 40 bytes without last; requester 1 joins after the first grant
      rst_dut();
      rem[2] = 40;
      ul[2] = 1'b0;
      drive();
      #1;
      cyc();
      chk("t3_first_grant", Grant, 4'h4);
      rem[1] = 3;
      nxt[1] = 8'hA0;
      drive();
      #1;
      for (int c = 0; c < 70; c++) cyc();
      for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
      exp_q.push_back(8'hA0);
      exp_q.push_back(8'hA1);
      exp_q.push_back(8'hA2);
      for (int i = 16; i < 40; i++) exp_q.push_back(8'(i));
      cmp_log("t3_log");
      chk("t3_hold_grant", Grant, 4'h4);
      chk("t3_hold_busy", Busy, 1'b1);

      // Fifo_full for 5 cycles mid-message
      rst_dut();
      rem[0] = 6;
      nxt[0] = 8'h10;
      drive();
      #1;
      cyc();
      cyc();
      cyc();
      Fifo_full = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("t4_full_wr_c%0d", c), Fifo_wr, 1'b0);
         chk($sformatf("t4_full_rdy_c%0d", c), Req_ready, 4'h0);
         chk($sformatf("t4_full_gnt_c%0d", c), Grant, 4'h1);
         cyc();
      end
      Fifo_full = 1'b0;
      #1;
      for (int c = 0; c < 6; c++) cyc();
      exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
      cmp_log("t4_log");
      chk("t4_rel_grant", Grant, 4'h0);

      // Enable low blocks arbitration
      rst_dut();
      Enable = 1'b0;
      rem[1] = 1;
      nxt[1] = 8'h77;
      drive();
      #1;
      for (int c = 0; c < 3; c++) begin
         cyc();
         chk($sformatf("t5_dis_grant_c%0d", c), Grant, 4'h0);
      end
      Enable = 1'b1;
      #1;
      chk("t5_en_same_cycle", Grant, 4'h0);
      cyc();
      chk("t5_en_grant", Grant, 4'h2);
      chk("t5_en_data", Fifo_data, 8'h77);
      cyc();
      chk("t5_rel_grant", Grant, 4'h0);

      // Async reset during byte 2 of a 4-byte message; rr_ptr is 1 before reset
      rem[0] = 4;
      nxt[0] = 8'h50;
      drive();
      #1;
      cyc();
      chk("t6_grant", Grant, 4'h1);
      cyc();
      chk("t6_byte2_wr", Fifo_wr, 1'b1);
      chk("t6_byte2_data", Fifo_data, 8'h51);
      Rst = 1'b1;
      #1;
      chk("t6_async_grant", Grant, 4'h0);
      chk("t6_async_busy", Busy, 1'b0);
      chk("t6_async_wr", Fifo_wr, 1'b0);
      chk("t6_async_ready", Req_ready, 4'h0);
      @(negedge Clk);
      Rst = 1'b0;
      rem[0] = 1;
      rem[3] = 1;
      drive();
      #1;
      cyc();
      chk("t6_post_rst_prio", Grant, 4'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uar_tx_arbiter.md
Name: uar_tx_arbiter

Overview:
Round-robin arbiter that shares the single UART TX FIFO write port (WrFifoTx / TxDataFifo) among N_REQ byte-stream requesters, e.g. the AXI slave interface, a debug/printf engine and a status reporter.
- Each requester transfers bytes over a valid/ready handshake.
- A grant is held until the requester marks its last byte, so messages never interleave.
- A grant is force-released after MAX_BURST bytes, so no requester can starve the others.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width written into the TX FIFO
MAX_BURST, 16, max bytes per grant before forced rotation (1..255)

Ports:
Clk  input  1  clock
Rst  input  1  asynchronous reset, active-high
Enable  input  1  global transfer enable; low stalls all transfers
Req_valid  input  N_REQ  per-requester byte valid
Req_data  input  N_REQ*DATA_W  per-requester byte; requester i uses bits [i*DATA_W +: DATA_W]
Req_last  input  N_REQ  marks last byte of a message; sampled with Req_valid
Req_ready  output  N_REQ  per-requester byte accepted when valid&ready
Fifo_full  input  1  TX FIFO full
Fifo_wr  output  1  TX FIFO write strobe
Fifo_data  output  DATA_W  TX FIFO write data
Grant  output  N_REQ  one-hot current owner, registered; all-zero when idle
Busy  output  1  registered; high while in XFER

Behaviour:
- FSM with two states, IDLE and XFER. Registers: state, Grant, idx (log2 N_REQ), rr_ptr (last served index), burst_cnt (8b).
- Reset values: state=IDLE, Grant=0, Busy=0, rr_ptr=N_REQ-1 (requester 0 has first priority), burst_cnt=0. Req_ready=0 and Fifo_wr=0 while in reset.
- IDLE:
  - If Enable and any Req_valid: pick the first valid index searching rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - Register the pick into Grant/idx, set burst_cnt=0, go to XFER. This costs 1 cycle.
  - Enable low in IDLE: no arbitration.
- XFER:
  - Req_ready[idx] = Enable & !Fifo_full. All other Req_ready bits are 0. This is combinational.
  - xfer = Req_valid[idx] & Req_ready[idx].
  - Fifo_wr = xfer. Fifo_data = Req_data slice idx. Both are combinational, zero latency. Fifo_data is don't-care when Fifo_wr=0.
  - On xfer: burst_cnt++.
  - Release (next state IDLE, Grant<=0, rr_ptr<=idx) when xfer & (Req_last[idx] | burst_cnt==MAX_BURST-1).
  - Owner dropping Req_valid mid-message: grant is held; the block waits indefinitely.
- Fifo_full: owner stalls. No byte is lost and no Fifo_wr is issued while Fifo_full=1.
- Enable deasserted in XFER: grant is held, transfers stall, and transfers resume on re-assertion.
- Gap after release: at least 1 idle cycle (the IDLE arbitration cycle) before the next grant.
- Forced rotation: after a forced release, the same requester may win again only if no other requester is valid.
- Simultaneous requests: lowest index after rr_ptr (modulo N_REQ) wins.
- Reset mid-transfer: immediate return to reset values. A partially sent message is not resumed; recovery is the requester's responsibility.

Test Plan:
- Reset, then Req_valid=0001, requester 0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) -> Grant=0001 one cycle after request; Fifo_wr pulses 3 cycles with data 41,42,43; Grant=0 and rr_ptr=0 after the third byte.
- Req_valid=1111, every requester sends a 1-byte message -> grant order 0,1,2,3; each grant separated by 1 idle cycle; exactly 4 Fifo_wr.
- Requester 2 streams 40 bytes with no last, MAX_BURST=16, requester 1 also valid -> req2 sends 16 bytes, req1 is granted, then req2 resumes; total Fifo_wr count is exact and no byte is duplicated or dropped.
- Fifo_full held high for 5 cycles mid-message -> Fifo_wr=0 and Req_ready=0 for those 5 cycles; the data sequence is unchanged after release.
- Enable=0 with Req_valid=0010 -> Grant stays 0; after Enable=1, Grant=0010 the next cycle.
- Rst asserted during byte 2 of a 4-byte message -> Grant=0, Busy=0, Fifo_wr=0 immediately (asynchronous); after reset, requester 0 has top priority.
